// File: rtl/conv_sequencer_pkg.sv
// Shared types and sizing helpers for the convolution sequencer slice.
package conv_sequencer_pkg;

    localparam int DATA_WIDTH = 16;

    typedef logic [DATA_WIDTH-1:0] data_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_K,
        ST_LOAD_M,
        ST_CLEAR,
        ST_TAP,
        ST_EMIT,
        ST_DONE
    } conv_state_t;

    function automatic int out_dim(input int n, input int k);
        return n - k + 1;
    endfunction

    // Never returns zero so that K=1 still yields a usable 1-bit field.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int kern_aw(input int k);
        return cnt_w(k * k);
    endfunction

    function automatic int mat_aw(input int n);
        return cnt_w(n * n);
    endfunction

endpackage

// File: rtl/conv_sequencer_if.sv
// Load stream, memory, MAC and result signals between the sequencer and its datapath.
interface conv_sequencer_if #(
    parameter int MATRIX_DIM = 16,
    parameter int CONV_DIM   = 3
);
    import conv_sequencer_pkg::*;

    logic                               in_valid;
    logic                               in_ready;
    data_t                              in_data;
    logic                               kern_we;
    logic [kern_aw(CONV_DIM)-1:0]       kern_addr;
    logic                               mat_we;
    logic [mat_aw(MATRIX_DIM)-1:0]      mat_addr;
    data_t                              wdata;
    logic                               mac_clr;
    logic                               mac_en;
    data_t                              mac_sum;
    logic                               out_valid;
    logic                               out_ready;
    data_t                              out_data;

    modport master (
        input  in_valid, in_data, mac_sum, out_ready,
        output in_ready, kern_we, kern_addr, mat_we, mat_addr, wdata,
               mac_clr, mac_en, out_valid, out_data
    );

    modport slave (
        output in_valid, in_data, mac_sum, out_ready,
        input  in_ready, kern_we, kern_addr, mat_we, mat_addr, wdata,
               mac_clr, mac_en, out_valid, out_data
    );

endinterface

// File: rtl/conv_addr_gen.sv
// Nested window (r,c) and tap (i,j) counters producing kernel and matrix read addresses.
module conv_addr_gen
    import conv_sequencer_pkg::*;
#(
    parameter int MATRIX_DIM = 16,
    parameter int CONV_DIM   = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          tap_step,
    input  logic                          win_step,
    output logic [kern_aw(CONV_DIM)-1:0]  kern_addr,
    output logic [mat_aw(MATRIX_DIM)-1:0] mat_addr,
    output logic                          last_tap,
    output logic                          last_window
);

    localparam int KAW = kern_aw(CONV_DIM);
    localparam int MAW = mat_aw(MATRIX_DIM);
    localparam int OD  = out_dim(MATRIX_DIM, CONV_DIM);
    localparam int TW  = cnt_w(CONV_DIM) + 1;
    localparam int WW  = cnt_w(OD) + 1;
    localparam logic [TW-1:0] TAP_LAST = TW'(CONV_DIM - 1);
    localparam logic [WW-1:0] WIN_LAST = WW'(OD - 1);

    logic [TW-1:0] i, j;
    logic [WW-1:0] r, c;
    int unsigned   kern_lin, mat_lin;

    // Tap counters wrap on their own after the last tap, ready for the next window.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            i <= '0;
            j <= '0;
            r <= '0;
            c <= '0;
        end else begin
            if (tap_step) begin
                if (j == TAP_LAST) begin
                    j <= '0;
                    i <= (i == TAP_LAST) ? '0 : i + 1'b1;
                end else begin
                    j <= j + 1'b1;
                end
            end
            if (win_step) begin
                if (c == WIN_LAST) begin
                    c <= '0;
                    r <= (r == WIN_LAST) ? '0 : r + 1'b1;
                end else begin
                    c <= c + 1'b1;
                end
            end
        end
    end

    assign kern_lin    = 32'(i) * CONV_DIM + 32'(j);
    assign mat_lin     = (32'(r) + 32'(i)) * MATRIX_DIM + 32'(c) + 32'(j);
    assign kern_addr   = KAW'(kern_lin);
    assign mat_addr    = MAW'(mat_lin);
    assign last_tap    = (i == TAP_LAST) && (j == TAP_LAST);
    assign last_window = (r == WIN_LAST) && (c == WIN_LAST);

endmodule

// File: rtl/conv_sequencer.sv
// Sequences one valid-mode 2-D convolution: load kernel/matrix, walk windows and taps, emit results.
//
// state   | meaning
// IDLE    | waiting for start
// LOAD_K  | accepting K*K kernel words
// LOAD_M  | accepting N*N matrix words
// CLEAR   | clearing the MAC for a new window
// TAP     | one MAC accumulate per kernel tap
// EMIT    | holding the window result until out_ready
// DONE    | one-cycle completion pulse
module conv_sequencer
    import conv_sequencer_pkg::*;
#(
    parameter int MATRIX_DIM = 16,
    parameter int CONV_DIM   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              reuse_kernel,
    conv_sequencer_if.master  bus,
    output logic              busy,
    output logic              done
);

    localparam int KAW = kern_aw(CONV_DIM);
    localparam int MAW = mat_aw(MATRIX_DIM);
    localparam int LW  = MAW + 1;
    localparam logic [LW-1:0] K_LAST = LW'(CONV_DIM * CONV_DIM - 1);
    localparam logic [LW-1:0] M_LAST = LW'(MATRIX_DIM * MATRIX_DIM - 1);

    conv_state_t    state;
    logic [LW-1:0]  load_cnt;
    logic           in_ready_q, mac_clr_q, mac_en_q, out_valid_q;
    logic           accept, tap_step, win_step;
    logic           last_tap, last_window;
    logic [KAW-1:0] gen_kern_addr;
    logic [MAW-1:0] gen_mat_addr;

    assign accept   = bus.in_valid & in_ready_q;
    assign tap_step = (state == ST_TAP);
    assign win_step = (state == ST_EMIT) & bus.out_ready;

    conv_addr_gen #(
        .MATRIX_DIM (MATRIX_DIM),
        .CONV_DIM   (CONV_DIM)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .clear       (state == ST_IDLE),
        .tap_step    (tap_step),
        .win_step    (win_step),
        .kern_addr   (gen_kern_addr),
        .mat_addr    (gen_mat_addr),
        .last_tap    (last_tap),
        .last_window (last_window)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            load_cnt    <= '0;
            in_ready_q  <= 1'b0;
            mac_clr_q   <= 1'b0;
            mac_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= reuse_kernel ? ST_LOAD_M : ST_LOAD_K;
                        load_cnt   <= '0;
                        in_ready_q <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ST_LOAD_K: begin
                    if (accept) begin
                        if (load_cnt == K_LAST) begin
                            load_cnt <= '0;
                            state    <= ST_LOAD_M;
                        end else begin
                            load_cnt <= load_cnt + 1'b1;
                        end
                    end
                end
                ST_LOAD_M: begin
                    if (accept) begin
                        if (load_cnt == M_LAST) begin
                            load_cnt   <= '0;
                            in_ready_q <= 1'b0;
                            mac_clr_q  <= 1'b1;
                            state      <= ST_CLEAR;
                        end else begin
                            load_cnt <= load_cnt + 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
                    mac_clr_q <= 1'b0;
                    mac_en_q  <= 1'b1;
                    state     <= ST_TAP;
                end
                ST_TAP: begin
                    if (last_tap) begin
                        mac_en_q    <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (last_window) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            mac_clr_q <= 1'b1;
                            state     <= ST_CLEAR;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Load addresses come from the word count; compute addresses from the window/tap walk.
    always_comb begin
        bus.kern_addr = '0;
        bus.mat_addr  = '0;
        case (state)
            ST_LOAD_K: bus.kern_addr = KAW'(load_cnt);
            ST_LOAD_M: bus.mat_addr  = MAW'(load_cnt);
            ST_TAP: begin
                bus.kern_addr = gen_kern_addr;
                bus.mat_addr  = gen_mat_addr;
            end
            default: ;
        endcase
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.kern_we   = accept & (state == ST_LOAD_K);
    assign bus.mat_we    = accept & (state == ST_LOAD_M);
    assign bus.wdata     = bus.in_data;
    assign bus.mac_clr   = mac_clr_q;
    assign bus.mac_en    = mac_en_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_valid_q ? bus.mac_sum : '0;

endmodule

// File: tb/tb_conv_sequencer.sv
// Randomized self-checking bench: two sequencer instances (K=2 and K=N) with memory/MAC models.
module tb_conv_sequencer;
    import conv_sequencer_pkg::*;

    localparam int N  = 4;
    localparam int K  = 2;
    localparam int KB = 4;
    localparam int OD = N - K + 1;

    logic clk = 1'b0;
    logic rst;
    logic start_a, reuse_a, busy_a, done_a;
    logic start_b, reuse_b, busy_b, done_b;

    always #5 clk = ~clk;

    conv_sequencer_if #(.MATRIX_DIM(N), .CONV_DIM(K))  ifa ();
    conv_sequencer_if #(.MATRIX_DIM(N), .CONV_DIM(KB)) ifb ();

    conv_sequencer #(.MATRIX_DIM(N), .CONV_DIM(K)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .reuse_kernel(reuse_a),
        .bus(ifa), .busy(busy_a), .done(done_a)
    );

    conv_sequencer #(.MATRIX_DIM(N), .CONV_DIM(KB)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .reuse_kernel(reuse_b),
        .bus(ifb), .busy(busy_b), .done(done_b)
    );

    // Datapath models: comb-read memories and a MAC with clear priority.
    data_t kmem_a[K*K], mmem_a[N*N], sum_a;
    data_t kmem_b[KB*KB], mmem_b[N*N], sum_b;

    always @(posedge clk) begin
        if (ifa.kern_we) kmem_a[ifa.kern_addr] <= ifa.wdata;
        if (ifa.mat_we)  mmem_a[ifa.mat_addr]  <= ifa.wdata;
        if (ifa.mac_clr)     sum_a <= '0;
        else if (ifa.mac_en) sum_a <= sum_a + kmem_a[ifa.kern_addr] * mmem_a[ifa.mat_addr];
        if (ifb.kern_we) kmem_b[ifb.kern_addr] <= ifb.wdata;
        if (ifb.mat_we)  mmem_b[ifb.mat_addr]  <= ifb.wdata;
        if (ifb.mac_clr)     sum_b <= '0;
        else if (ifb.mac_en) sum_b <= sum_b + kmem_b[ifb.kern_addr] * mmem_b[ifb.mat_addr];
    end
    assign ifa.mac_sum = sum_a;
    assign ifb.mac_sum = sum_b;

    // Result consumer: 0 = always ready, 1 = random, 2 = ready one cycle in three.
    int ready_mode = 0;
    int rdy_ph = 0;
    always begin
        @(posedge clk);
        #1;
        case (ready_mode)
            1:       ifa.out_ready = 1'($urandom_range(0, 1));
            2:       ifa.out_ready = (rdy_ph == 2);
            default: ifa.out_ready = 1'b1;
        endcase
        ifb.out_ready = 1'b1;
        rdy_ph = (rdy_ph + 1) % 3;
    end

    int cyc = 0;
    int kwr_a = 0, mwr_a = 0, acc_a = 0, clr_a = 0, done_cnt_a = 0, clr_cyc_a = 0;
    int addr_err_a = 0, stall_err_a = 0, en_err_a = 0, lat_err_a = 0;
    int done_cnt_b = 0;
    logic  stalled_a = 1'b0;
    data_t held_a;
    data_t got_a[$], got_b[$];

    always @(negedge clk) begin
        cyc++;
        if (ifa.in_valid && ifa.in_ready) acc_a++;
        if (ifa.kern_we) begin
            if (int'(ifa.kern_addr) != kwr_a % (K*K)) addr_err_a++;
            kwr_a++;
        end
        if (ifa.mat_we) begin
            if (int'(ifa.mat_addr) != mwr_a % (N*N)) addr_err_a++;
            mwr_a++;
        end
        if (ifa.mac_clr) begin
            clr_a++;
            clr_cyc_a = cyc;
        end
        if (ifa.out_valid && ifa.mac_en) en_err_a++;
        if (ifa.out_valid) begin
            if (stalled_a && ifa.out_data != held_a) stall_err_a++;
            if (ifa.out_ready) begin
                got_a.push_back(ifa.out_data);
                if (ready_mode == 0 && cyc - clr_cyc_a + 1 != K*K + 2) lat_err_a++;
                stalled_a = 1'b0;
            end else begin
                stalled_a = 1'b1;
                held_a    = ifa.out_data;
            end
        end else begin
            stalled_a = 1'b0;
        end
        if (done_a) done_cnt_a++;
        if (ifb.out_valid && ifb.out_ready) got_b.push_back(ifb.out_data);
        if (done_b) done_cnt_b++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    data_t new_k[K*K], new_m[N*N], ref_k[K*K], ref_m[N*N];
    data_t kb[KB*KB], mb[N*N];

    task automatic load(input bit sel_b, input bit to_k, input bit gapped);
        int    n, idx, guard;
        data_t w;
        logic  v, rdy;
        n = sel_b ? 16 : (to_k ? K*K : N*N);
        idx = 0;
        guard = 0;
        while (idx < n && guard < 1000) begin
            if (sel_b) w = to_k ? kb[idx] : mb[idx];
            else if (to_k) w = new_k[idx];
            else w = new_m[idx];
            v   = !(gapped && (guard % 2 == 1));
            rdy = sel_b ? ifb.in_ready : ifa.in_ready;
            if (sel_b) begin
                ifb.in_valid = v;
                ifb.in_data  = w;
            end else begin
                ifa.in_valid = v;
                ifa.in_data  = w;
            end
            if (v && rdy) idx++;
            tick();
            guard++;
        end
        ifa.in_valid = 1'b0;
        ifb.in_valid = 1'b0;
    endtask

    // Reference: direct valid-mode convolution of the stored kernel over the new matrix.
    task automatic job_a(input bit reuse, input bit gapped, input int mode, output int first);
        data_t exp_q[$];
        data_t s;
        int b_kwr, b_mwr, b_acc, b_clr, b_done, b_addr, b_stall, b_en, b_lat, guard;
        if (!reuse) ref_k = new_k;
        ref_m = new_m;
        for (int r = 0; r < OD; r++)
            for (int c = 0; c < OD; c++) begin
                s = '0;
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++)
                        s = s + ref_k[i*K + j] * ref_m[(r + i)*N + c + j];
                exp_q.push_back(s);
            end
        first = got_a.size();
        b_kwr = kwr_a; b_mwr = mwr_a; b_acc = acc_a; b_clr = clr_a; b_done = done_cnt_a;
        b_addr = addr_err_a; b_stall = stall_err_a; b_en = en_err_a; b_lat = lat_err_a;
        ready_mode = mode;
        start_a = 1'b1;
        reuse_a = reuse;
        tick();
        start_a = 1'b0;
        reuse_a = 1'b0;
        if (!reuse) load(1'b0, 1'b1, gapped);
        load(1'b0, 1'b0, gapped);
        guard = 0;
        while (busy_a && guard < 3000) begin
            tick();
            guard++;
        end
        tick();
        check("busy_after_job", busy_a, 0);
        check("result_count", got_a.size() - first, exp_q.size());
        for (int k = 0; k < exp_q.size() && first + k < got_a.size(); k++)
            check("result", got_a[first + k], exp_q[k]);
        check("done_pulses", done_cnt_a - b_done, 1);
        check("kern_writes", kwr_a - b_kwr, reuse ? 0 : K*K);
        check("mat_writes", mwr_a - b_mwr, N*N);
        check("accepted", acc_a - b_acc, reuse ? N*N : K*K + N*N);
        check("mac_clears", clr_a - b_clr, OD*OD);
        check("addr_seq", addr_err_a - b_addr, 0);
        check("stall_hold", stall_err_a - b_stall, 0);
        check("mac_en_in_emit", en_err_a - b_en, 0);
        check("window_latency", lat_err_a - b_lat, 0);
    endtask

    int gold[9] = '{10, 14, 18, 26, 30, 34, 42, 46, 50};

    task automatic fill_test1();
        for (int k = 0; k < K*K; k++) new_k[k] = 16'd1;
        for (int x = 0; x < N; x++)
            for (int y = 0; y < N; y++) new_m[x*N + y] = data_t'(4*x + y);
    endtask

    initial begin
        int first, base, guard, b_done;
        data_t exp_b;
        rst = 1'b1;
        start_a = 1'b0; reuse_a = 1'b0; start_b = 1'b0; reuse_b = 1'b0;
        ifa.in_valid = 1'b0; ifa.in_data = '0;
        ifb.in_valid = 1'b0; ifb.in_data = '0;
        repeat (3) tick();
        check("reset_ctrl_a", {busy_a, done_a, ifa.in_ready, ifa.kern_we, ifa.mat_we,
                               ifa.mac_clr, ifa.mac_en, ifa.out_valid}, 0);
        check("reset_addr_a", {ifa.kern_addr, ifa.mat_addr}, 0);
        check("reset_ctrl_b", {busy_b, done_b, ifb.in_ready, ifb.mac_en, ifb.out_valid}, 0);
        rst = 1'b0;
        tick();

        fill_test1();
        job_a(1'b0, 1'b0, 0, first);
        for (int k = 0; k < 9; k++) check("gold_t1", got_a[first + k], gold[k]);

        job_a(1'b0, 1'b0, 2, first);
        for (int k = 0; k < 9; k++) check("gold_t2", got_a[first + k], gold[k]);

        for (int k = 0; k < N*N; k++) new_m[k] = 16'd2;
        job_a(1'b1, 1'b0, 0, first);
        for (int k = 0; k < 9; k++) check("reuse_all8", got_a[first + k], 8);

        for (int k = 0; k < K*K; k++) new_k[k] = data_t'($urandom_range(0, 255));
        for (int k = 0; k < N*N; k++) new_m[k] = data_t'($urandom_range(0, 255));
        job_a(1'b0, 1'b1, 0, first);

        for (int t = 0; t < 5; t++) begin
            for (int k = 0; k < K*K; k++) new_k[k] = data_t'($urandom);
            for (int k = 0; k < N*N; k++) new_m[k] = data_t'($urandom);
            job_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), first);
        end

        // Abort during the third TAP cycle of the fourth window.
        fill_test1();
        ref_k = new_k;
        ready_mode = 0;
        b_done = done_cnt_a;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        load(1'b0, 1'b1, 1'b0);
        load(1'b0, 1'b0, 1'b0);
        base = got_a.size();
        guard = 0;
        while (got_a.size() - base < 3 && guard < 500) begin
            tick();
            guard++;
        end
        repeat (3) tick();
        check("abort_in_tap", ifa.mac_en, 1);
        rst = 1'b1;
        tick();
        check("abort_ctrl", {busy_a, done_a, ifa.in_ready, ifa.kern_we, ifa.mat_we,
                             ifa.mac_clr, ifa.mac_en, ifa.out_valid}, 0);
        check("abort_addr", {ifa.kern_addr, ifa.mat_addr, ifa.out_data}, 0);
        rst = 1'b0;
        repeat (20) tick();
        check("abort_results", got_a.size() - base, 3);
        check("abort_no_done", done_cnt_a - b_done, 0);
        job_a(1'b0, 1'b0, 0, first);
        for (int k = 0; k < 9; k++) check("gold_after_abort", got_a[first + k], gold[k]);

        // K = N: single window; extra start pulses while busy must be ignored.
        exp_b = '0;
        for (int k = 0; k < 16; k++) begin
            kb[k] = data_t'($urandom_range(0, 255));
            mb[k] = data_t'($urandom_range(0, 255));
            exp_b = exp_b + kb[k] * mb[k];
        end
        ready_mode = 0;
        start_b = 1'b1;
        tick();
        load(1'b1, 1'b1, 1'b0);
        load(1'b1, 1'b0, 1'b0);
        guard = 0;
        while (!ifb.out_valid && guard < 200) begin
            start_b = ~start_b;
            tick();
            guard++;
        end
        start_b = 1'b0;
        guard = 0;
        while (busy_b && guard < 200) begin
            tick();
            guard++;
        end
        repeat (5) tick();
        check("kn_busy", busy_b, 0);
        check("kn_results", got_b.size(), 1);
        check("kn_value", got_b.size() > 0 ? got_b[0] : ~exp_b, exp_b);
        check("kn_done", done_cnt_b, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
